dwm_arbiter: RTL and testbench
==============================

Name: dwm_arbiter

Overview:
Round-robin arbiter that shares the single-port data word memory (registered address, 1-cycle read latency) among NC logic-unit cores. It selects one requester per cycle and drives the memory's write-enable, address and write-data from that core. Read data is returned to the granted core one cycle later, tagged by a per-core valid. A per-core LOCK input keeps ownership across consecutive accesses, so read-modify-write sequences are atomic.

Parameters:
NC, 4, number of requesting cores (2..8)
AW, 16, address width (matches memory A)
DW, 32, data width (matches memory DI/DQ)

Ports:
CLK  in  1  clock, all state on rising edge
RST_N  in  1  asynchronous active-low reset
REQ  in  NC  per-core access request
WE  in  NC  per-core write (1) / read (0) qualifier
LOCK  in  NC  per-core hold-ownership request, sampled with REQ
A  in  NC*AW  per-core address, core i at [i*AW +: AW]
DI  in  NC*DW  per-core write data, core i at [i*DW +: DW]
GNT  out  NC  one-hot grant, combinational, access completes at next rising edge
RVALID  out  NC  one-hot, registered, read data valid for core i this cycle
RDATA  out  DW  read data, = M_DQ (pass-through), meaningful only when RVALID!=0
M_WE  out  1  memory write enable
M_A  out  AW  memory address
M_DI  out  DW  memory write data
M_DQ  in  DW  memory read data

Behaviour:
- Reset (RST_N=0, async): state=ARB, last-grant pointer LAST=NC-1 (core 0 highest priority), owner cleared, RVALID=0. While in reset, GNT=0 and M_WE=0. Reset mid-lock or mid-read drops the lock and any pending RVALID with no completion.
- States: ARB, LOCKED (owner index OWN held in a register).
- ARB: GNT selects the first core i with REQ[i]=1, searching LAST+1, LAST+2, ... modulo NC. If no REQ bit is set, GNT=0, M_WE=0, and M_A/M_DI hold the core-0 values (don't-care).
- Memory drive: M_WE=WE[g]&REQ[g], M_A=A[g], M_DI=DI[g] for granted core g. All are combinational from inputs.
- At a rising edge with GNT[g]=1:
  - LAST<=g.
  - If WE[g]=0, RVALID<=onehot(g) next cycle; otherwise RVALID<=0.
  - If LOCK[g]=1, go to LOCKED with OWN=g.
- LOCKED: GNT=onehot(OWN) whenever REQ[OWN]=1; other cores are never granted. Transitions:
  - REQ[OWN]=1 and LOCK[OWN]=0 at an edge: the access completes, return to ARB.
  - REQ[OWN]=0 at an edge: no access, return to ARB (lock abandoned).
- Latency: a write commits at the grant edge. Read data appears on RDATA with RVALID in the cycle immediately after the grant edge. Back-to-back reads are supported, one per cycle, in any order of cores.
- Cores must hold REQ/WE/A/DI/LOCK stable until they see GNT high at a rising edge. The arbiter does not queue requests.
- Simultaneous events: grant and RVALID for different (or the same) cores can occur in one cycle. A read followed by a write to the same address by another core returns the old data (memory read-before-write ordering).
- Fairness: with all REQ held high and no LOCK, grants rotate 0,1,...,NC-1,0,... Worst-case wait without locks is NC-1 cycles.
- No width conversion: A/DI pass through unmodified. Address range checking is the memory's concern.

Test Plan:
- Reset: assert RST_N=0 mid-read of core 2 -> RVALID=0, GNT=0, M_WE=0 immediately. After release, REQ=4'b1111 -> first GNT=4'b0001.
- Rotation: REQ=4'b1111, WE=0, A_i=i -> GNT sequence 0001,0010,0100,1000,0001. RVALID follows one cycle later with RDATA=MEM[i] (200,300,800,500).
- Write/read: core 1 writes A=9 DI=32'h1234 (GNT=0010, M_WE=1). Next cycle core 3 reads A=9 -> RVALID=1000, RDATA=32'h1234.
- Lock RMW: core 0 with LOCK=1 reads A=5 (value 2) while core 2 holds REQ. Core 0 then writes A=5 DI=3 with LOCK=0 -> GNT=0001 for both cycles, core 2 granted on the third cycle, MEM[5]=3.
- Lock abandon: enter LOCKED for core 1, then drop REQ[1] -> returns to ARB, next pending core granted the following cycle, no spurious M_WE.
- Idle: REQ=0 for 10 cycles -> GNT=0, M_WE=0, RVALID=0 throughout, LAST unchanged.

Source files
------------

// File: rtl/dwm_arbiter.sv
// Round-robin arbiter that shares one single-port data word memory among
// NC cores. A grant is decided combinationally from the current requests and
// completes at the next rising edge. Reads return one cycle after the grant
// edge. A core holding LOCK keeps ownership, so read-modify-write is atomic.
module dwm_arbiter #(
    parameter int NC = 4,
    parameter int AW = 16,
    parameter int DW = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [NC-1:0]    REQ,
    input  logic [NC-1:0]    WE,
    input  logic [NC-1:0]    LOCK,
    input  logic [NC*AW-1:0] A,
    input  logic [NC*DW-1:0] DI,
    output logic [NC-1:0]    GNT,
    output logic [NC-1:0]    RVALID,
    output logic [DW-1:0]    RDATA,
    output logic             M_WE,
    output logic [AW-1:0]    M_A,
    output logic [DW-1:0]    M_DI,
    input  logic [DW-1:0]    M_DQ
);

    localparam int IW = (NC > 1) ? $clog2(NC) : 1;

    typedef enum logic [0:0] {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   last;
    logic [IW-1:0]   own;
    logic [IW-1:0]   own_nxt;
    logic [NC-1:0]   rvalid_q;

    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    logic            gnt_vld;
    logic [IW-1:0]   gnt_idx;

    // Round-robin search: first requester after the last granted core.
    always_comb begin
        int            cand;
        logic [IW-1:0] cidx;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cidx       = '0;
        for (int k = 1; k <= NC; k++) begin
            cand = (int'(last) + k) % NC;
            cidx = IW'(cand);
            if (!pick_found && REQ[cidx]) begin
                pick_found = 1'b1;
                pick_idx   = cidx;
            end
        end
    end

    // Grant selection and next-state: the lock owner is exclusive while locked,
    // and a dropped owner request abandons the lock with no access that cycle.
    always_comb begin
        state_nxt = state;
        own_nxt   = own;
        gnt_vld   = 1'b0;
        gnt_idx   = '0;

        if (state == LOCKED) begin
            if (REQ[own]) begin
                gnt_vld = 1'b1;
                gnt_idx = own;
            end
        end else begin
            gnt_vld = pick_found;
            gnt_idx = pick_idx;
        end

        // No grant may escape while the block is held in reset.
        if (!RST_N) begin
            gnt_vld = 1'b0;
            gnt_idx = '0;
        end

        if (gnt_vld) begin
            if (LOCK[gnt_idx]) begin
                state_nxt = LOCKED;
                own_nxt   = gnt_idx;
            end else begin
                state_nxt = ARB;
            end
        end else if (state == LOCKED) begin
            state_nxt = ARB;
        end
    end

    // Memory drive follows the granted core; with no grant, core 0 is shown.
    always_comb begin
        GNT  = '0;
        M_WE = 1'b0;
        M_A  = A[gnt_idx*AW +: AW];
        M_DI = DI[gnt_idx*DW +: DW];
        if (gnt_vld) begin
            GNT  = NC'(1) << gnt_idx;
            M_WE = WE[gnt_idx] & REQ[gnt_idx];
        end
    end

    // Control state: FSM, round-robin pointer, lock owner and read-valid tag.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= ARB;
            last     <= IW'(NC - 1);
            own      <= '0;
            rvalid_q <= '0;
        end else begin
            state <= state_nxt;
            own   <= own_nxt;
            if (gnt_vld) begin
                last <= gnt_idx;
            end
            if (gnt_vld && !WE[gnt_idx]) begin
                rvalid_q <= GNT;
            end else begin
                rvalid_q <= '0;
            end
        end
    end

    assign RVALID = rvalid_q;
    assign RDATA  = M_DQ;

endmodule

// File: tb/tb_dwm_arbiter.sv
// Directed bench for dwm_arbiter with a small read-before-write memory model.
module tb_dwm_arbiter;

    logic          CLK;
    logic          RST_N;
    logic [3:0]    req;
    logic [3:0]    we;
    logic [3:0]    lock;
    logic [15:0]   a_c [4];
    logic [31:0]   d_c [4];
    logic [63:0]   A;
    logic [127:0]  DI;
    logic [3:0]    GNT;
    logic [3:0]    RVALID;
    logic [31:0]   RDATA;
    logic          M_WE;
    logic [15:0]   M_A;
    logic [31:0]   M_DI;
    logic [31:0]   M_DQ;
    logic [31:0]   mem [256];

    int total;
    int bad;

    assign A  = {a_c[3], a_c[2], a_c[1], a_c[0]};
    assign DI = {d_c[3], d_c[2], d_c[1], d_c[0]};

    dwm_arbiter #(.NC(4), .AW(16), .DW(32)) dut (
        .CLK(CLK), .RST_N(RST_N), .REQ(req), .WE(we), .LOCK(lock),
        .A(A), .DI(DI), .GNT(GNT), .RVALID(RVALID), .RDATA(RDATA),
        .M_WE(M_WE), .M_A(M_A), .M_DI(M_DI), .M_DQ(M_DQ)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Single-port memory: registered address, read-before-write.
    always @(posedge CLK) begin
        M_DQ <= mem[M_A[7:0]];
        if (M_WE) mem[M_A[7:0]] <= M_DI;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        req = 4'b1111; we = 4'b1111; lock = 4'b0000;
        for (int i = 0; i < 4; i++) begin a_c[i] = 16'd0; d_c[i] = 32'd0; end
        repeat (2) @(posedge CLK);
        #1;
        total++; if (GNT !== 4'b0000) begin bad++; $display("FAIL rst_gnt: got %b want 0000", GNT); end
        total++; if (RVALID !== 4'b0000) begin bad++; $display("FAIL rst_rvalid: got %b want 0000", RVALID); end
        total++; if (M_WE !== 1'b0) begin bad++; $display("FAIL rst_mwe: got %b want 0", M_WE); end
        // core 2 read, then reset lands while its data is pending
        req = 4'b0100; we = 4'b0000; a_c[2] = 16'd2;
        RST_N = 1'b1;
        #1;
        total++; if (GNT !== 4'b0100) begin bad++; $display("FAIL rst_c2_gnt: got %b want 0100", GNT); end
        tick();
        total++; if (RVALID !== 4'b0100) begin bad++; $display("FAIL rst_c2_rvalid: got %b want 0100", RVALID); end
        total++; if (RDATA !== 32'd800) begin bad++; $display("FAIL rst_c2_rdata: got %0d want 800", RDATA); end
        we = 4'b0100;
        RST_N = 1'b0;
        #1;
        total++; if (RVALID !== 4'b0000) begin bad++; $display("FAIL rst_mid_rvalid: got %b want 0000", RVALID); end
        total++; if (GNT !== 4'b0000) begin bad++; $display("FAIL rst_mid_gnt: got %b want 0000", GNT); end
        total++; if (M_WE !== 1'b0) begin bad++; $display("FAIL rst_mid_mwe: got %b want 0", M_WE); end
        we = 4'b0000; req = 4'b1111;
        for (int i = 0; i < 4; i++) a_c[i] = 16'(i);
        RST_N = 1'b1;
        #1;
        total++; if (GNT !== 4'b0001) begin bad++; $display("FAIL rst_first_gnt: got %b want 0001", GNT); end
    endtask

    task automatic test_rotation();
        logic [3:0]  exp_g [5];
        logic [31:0] exp_d [5];
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100; exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
        exp_d[0] = 32'd200; exp_d[1] = 32'd300; exp_d[2] = 32'd800; exp_d[3] = 32'd500; exp_d[4] = 32'd200;
        for (int k = 0; k < 5; k++) begin
            total++; if (GNT !== exp_g[k]) begin bad++; $display("FAIL rot_gnt[%0d]: got %b want %b", k, GNT, exp_g[k]); end
            tick();
            total++; if (RVALID !== exp_g[k]) begin bad++; $display("FAIL rot_rvalid[%0d]: got %b want %b", k, RVALID, exp_g[k]); end
            total++; if (RDATA !== exp_d[k]) begin bad++; $display("FAIL rot_rdata[%0d]: got %0d want %0d", k, RDATA, exp_d[k]); end
        end
    endtask

    task automatic test_write_read();
        req = 4'b0010; we = 4'b0010; a_c[1] = 16'd9; d_c[1] = 32'h1234;
        #1;
        total++; if (GNT !== 4'b0010) begin bad++; $display("FAIL wr_gnt: got %b want 0010", GNT); end
        total++; if (M_WE !== 1'b1) begin bad++; $display("FAIL wr_mwe: got %b want 1", M_WE); end
        total++; if (M_A !== 16'd9) begin bad++; $display("FAIL wr_ma: got %h want 0009", M_A); end
        total++; if (M_DI !== 32'h1234) begin bad++; $display("FAIL wr_mdi: got %h want 00001234", M_DI); end
        tick();
        req = 4'b1000; we = 4'b0000; a_c[3] = 16'd9;
        #1;
        total++; if (RVALID !== 4'b0000) begin bad++; $display("FAIL wr_no_rvalid: got %b want 0000", RVALID); end
        total++; if (GNT !== 4'b1000) begin bad++; $display("FAIL rd_gnt: got %b want 1000", GNT); end
        total++; if (M_WE !== 1'b0) begin bad++; $display("FAIL rd_mwe: got %b want 0", M_WE); end
        tick();
        total++; if (RVALID !== 4'b1000) begin bad++; $display("FAIL rd_rvalid: got %b want 1000", RVALID); end
        total++; if (RDATA !== 32'h1234) begin bad++; $display("FAIL rd_rdata: got %h want 00001234", RDATA); end
    endtask

    task automatic test_lock_rmw();
        req = 4'b0101; we = 4'b0000; lock = 4'b0001; a_c[0] = 16'd5; a_c[2] = 16'd5;
        #1;
        total++; if (GNT !== 4'b0001) begin bad++; $display("FAIL rmw_rd_gnt: got %b want 0001", GNT); end
        tick();
        we = 4'b0001; lock = 4'b0000; d_c[0] = 32'd3;
        #1;
        total++; if (RVALID !== 4'b0001) begin bad++; $display("FAIL rmw_rvalid: got %b want 0001", RVALID); end
        total++; if (RDATA !== 32'd2) begin bad++; $display("FAIL rmw_rdata: got %0d want 2", RDATA); end
        total++; if (GNT !== 4'b0001) begin bad++; $display("FAIL rmw_wr_gnt: got %b want 0001", GNT); end
        total++; if (M_WE !== 1'b1) begin bad++; $display("FAIL rmw_wr_mwe: got %b want 1", M_WE); end
        total++; if (M_DI !== 32'd3) begin bad++; $display("FAIL rmw_wr_mdi: got %0d want 3", M_DI); end
        tick();
        req = 4'b0100; we = 4'b0000;
        #1;
        total++; if (GNT !== 4'b0100) begin bad++; $display("FAIL rmw_c2_gnt: got %b want 0100", GNT); end
        total++; if (mem[5] !== 32'd3) begin bad++; $display("FAIL rmw_mem5: got %0d want 3", mem[5]); end
        tick();
        total++; if (RVALID !== 4'b0100) begin bad++; $display("FAIL rmw_c2_rvalid: got %b want 0100", RVALID); end
        total++; if (RDATA !== 32'd3) begin bad++; $display("FAIL rmw_c2_rdata: got %0d want 3", RDATA); end
    endtask

    task automatic test_lock_abandon();
        req = 4'b0010; we = 4'b0000; lock = 4'b0010; a_c[1] = 16'd0;
        #1;
        total++; if (GNT !== 4'b0010) begin bad++; $display("FAIL ab_enter_gnt: got %b want 0010", GNT); end
        tick();
        // owner keeps the memory even though core 3 would win round-robin
        req = 4'b1011; a_c[3] = 16'd20; d_c[3] = 32'd77;
        #1;
        total++; if (GNT !== 4'b0010) begin bad++; $display("FAIL ab_hold_gnt: got %b want 0010", GNT); end
        tick();
        req = 4'b1001; we = 4'b1001; lock = 4'b0000;
        #1;
        total++; if (GNT !== 4'b0000) begin bad++; $display("FAIL ab_drop_gnt: got %b want 0000", GNT); end
        total++; if (M_WE !== 1'b0) begin bad++; $display("FAIL ab_drop_mwe: got %b want 0", M_WE); end
        total++; if (RVALID !== 4'b0010) begin bad++; $display("FAIL ab_rvalid: got %b want 0010", RVALID); end
        total++; if (RDATA !== 32'd200) begin bad++; $display("FAIL ab_rdata: got %0d want 200", RDATA); end
        tick();
        #1;
        total++; if (GNT !== 4'b1000) begin bad++; $display("FAIL ab_next_gnt: got %b want 1000", GNT); end
        total++; if (M_WE !== 1'b1) begin bad++; $display("FAIL ab_next_mwe: got %b want 1", M_WE); end
        total++; if (M_A !== 16'd20) begin bad++; $display("FAIL ab_next_ma: got %0d want 20", M_A); end
        tick();
        total++; if (mem[20] !== 32'd77) begin bad++; $display("FAIL ab_mem20: got %0d want 77", mem[20]); end
    endtask

    task automatic test_idle();
        // core 1 read moves the pointer to 1 before the idle stretch
        req = 4'b0010; we = 4'b0000; a_c[1] = 16'd9;
        #1;
        total++; if (GNT !== 4'b0010) begin bad++; $display("FAIL idle_pre_gnt: got %b want 0010", GNT); end
        tick();
        req = 4'b0000; we = 4'b1111;
        total++; if (RVALID !== 4'b0010) begin bad++; $display("FAIL idle_pre_rvalid: got %b want 0010", RVALID); end
        total++; if (RDATA !== 32'h1234) begin bad++; $display("FAIL idle_pre_rdata: got %h want 00001234", RDATA); end
        for (int c = 0; c < 10; c++) begin
            tick();
            total++; if (GNT !== 4'b0000) begin bad++; $display("FAIL idle_gnt[%0d]: got %b want 0000", c, GNT); end
            total++; if (M_WE !== 1'b0) begin bad++; $display("FAIL idle_mwe[%0d]: got %b want 0", c, M_WE); end
            total++; if (RVALID !== 4'b0000) begin bad++; $display("FAIL idle_rvalid[%0d]: got %b want 0000", c, RVALID); end
        end
        req = 4'b1111; we = 4'b0000;
        #1;
        total++; if (GNT !== 4'b0100) begin bad++; $display("FAIL idle_last_gnt: got %b want 0100", GNT); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[0] = 32'd200; mem[1] = 32'd300; mem[2] = 32'd800; mem[3] = 32'd500;
        mem[5] = 32'd2;
        test_reset();
        test_rotation();
        test_write_read();
        test_lock_rmw();
        test_lock_abandon();
        test_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
